uart_rx_mmio: RTL and testbench



---
 rtl/uart_rx_mmio.sv | 157 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: oversampled RX deserializer feeding a small FIFO,
// with data/status registers on the OTTER IOBUS (write to data pops, status is W1C).
module uart_rx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] RX_DATA_AD   = 32'h11240000,
  parameter logic [31:0] RX_STAT_AD   = 32'h11280000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RX,
  input  logic [31:0] IOBUS_ADDR,
  input  logic        IOBUS_WR,
  input  logic [31:0] IOBUS_OUT,
  output logic [31:0] IOBUS_IN,
  output logic        RX_INTR
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT1    = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          r_rx_meta, r_rx_s, r_rx_prev;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovr, r_ferr;

  logic w_stop_done, w_push, w_ferr_set;
  logic w_empty, w_full, w_pop, w_push_ok, w_ovr_set, w_stat_wr;

  assign w_stop_done = (r_state == S_STOP) && (r_cnt == FULL_M1);
  assign w_push      = w_stop_done && r_rx_s;
  assign w_ferr_set  = w_stop_done && !r_rx_s;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign w_pop       = IOBUS_WR && (IOBUS_ADDR == RX_DATA_AD) && !w_empty;
  assign w_stat_wr   = IOBUS_WR && (IOBUS_ADDR == RX_STAT_AD);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovr_set   = w_push && w_full && !w_pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_prev && !r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT1;
        2'b01:   r_count <= r_count - CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // New errors take priority over a same-cycle write-1-to-clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_stat_wr & IOBUS_OUT[1]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_stat_wr & IOBUS_OUT[2]));
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == RX_DATA_AD) begin
      if (!w_empty) IOBUS_IN = {24'b0, r_mem[r_rptr]};
    end else if (IOBUS_ADDR == RX_STAT_AD) begin
      IOBUS_IN = {28'b0, w_full, r_ferr, r_ovr, !w_empty};
    end
  end

  assign RX_INTR = !w_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: directed scenarios plus random frames and bus traffic,
// checked every cycle against a sample-schedule model of the receiver and FIFO.
module tb_uart_rx_mmio;

  localparam int          CPB     = 16;
  localparam int          HALF    = CPB / 2;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] DATA_AD = 32'h11240000;
  localparam logic [31:0] STAT_AD = 32'h11280000;
  localparam logic [31:0] OTHR_AD = 32'h11200000;

  logic        clk = 1'b0;
  logic        rst_n, rx, wr;
  logic [31:0] addr, wdata, rdata;
  logic        intr;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .RX_DATA_AD  (DATA_AD),
    .RX_STAT_AD  (STAT_AD)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .RX        (rx),
    .IOBUS_ADDR(addr),
    .IOBUS_WR  (wr),
    .IOBUS_OUT (wdata),
    .IOBUS_IN  (rdata),
    .RX_INTR   (intr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: rx_s is RX delayed two clocks; a frame whose start edge lands at
  // index k samples rx_s at k+HALF (start), k+HALF+j*CPB (data j=1..8), k+HALF+9*CPB (stop).
  logic [7:0] q[$];
  bit         m_ovr, m_ferr, m_meta, m_s, m_prev, m_busy;
  int         m_off;
  logic [7:0] m_sh;

  task automatic m_reset();
    q.delete();
    m_ovr = 0; m_ferr = 0;
    m_meta = 1; m_s = 1; m_prev = 1;
    m_busy = 0; m_off = 0; m_sh = '0;
  endtask

  task automatic m_step();
    bit s_cur, s_prev, push, fe, pop, stw;
    s_cur = m_s; s_prev = m_prev; push = 0; fe = 0;
    if (m_busy) begin
      m_off++;
      if (m_off == HALF) begin
        if (s_cur) m_busy = 0;
      end else if (m_off == HALF + 9 * CPB) begin
        m_busy = 0;
        if (s_cur) push = 1; else fe = 1;
      end else if (m_off > HALF && (m_off - HALF) % CPB == 0) begin
        m_sh = {s_cur, m_sh[7:1]};
      end
    end else if (s_prev && !s_cur) begin
      m_busy = 1;
      m_off  = 0;
    end
    pop = wr && (addr == DATA_AD) && (q.size() != 0);
    stw = wr && (addr == STAT_AD);
    if (pop) void'(q.pop_front());
    if (stw) begin
      if (wdata[1]) m_ovr  = 0;
      if (wdata[2]) m_ferr = 0;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(m_sh);
      else m_ovr = 1;
    end
    if (fe) m_ferr = 1;
    m_prev = m_s; m_s = m_meta; m_meta = rx;
  endtask

  function automatic logic [31:0] exp_in();
    if (addr == DATA_AD) return (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
    if (addr == STAT_AD)
      return {28'b0, q.size() == DEPTH, m_ferr, m_ovr, q.size() != 0};
    return 32'h0;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("iobus_in", rdata, exp_in());
      chk("rx_intr", {31'b0, intr}, {31'b0, q.size() != 0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    wr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(logic [7:0] b, bit stop, int pop_at, int rst_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      rx = fr[i / CPB];
      if (pop_at >= 0) begin
        wr = (i == pop_at);
        if (i == pop_at) addr = DATA_AD;
      end
      if (rst_at >= 0) begin
        if (i == rst_at)     rst_n = 1'b0;
        if (i == rst_at + 2) rst_n = 1'b1;
      end
      tick();
    end
    if (pop_at >= 0) wr = 1'b0;
    rx = 1'b1;
  endtask

  task automatic pop();
    addr = DATA_AD; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic stat_wr(logic [31:0] v);
    addr = STAT_AD; wdata = v; wr = 1'b1;
    tick();
    wr = 1'b0; wdata = '0;
  endtask

  task automatic read_chk(logic [31:0] a, logic [31:0] exp, string name);
    addr = a;
    @(negedge clk);
    chk(name, rdata, exp);
    tick();
  endtask

  bit done;

  initial begin
    rst_n = 1'b0; rx = 1'b1; wr = 1'b0; addr = '0; wdata = '0; done = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    read_chk(DATA_AD, 32'h0, "rst_data");
    read_chk(STAT_AD, 32'h0, "rst_stat");
    chk("rst_intr", {31'b0, intr}, 32'h0);

    // single frame
    send(8'hA5, 1, -1, -1); idle(4);
    chk("a5_intr", {31'b0, intr}, 32'h1);
    read_chk(STAT_AD, 32'h1, "a5_stat");
    read_chk(DATA_AD, 32'hA5, "a5_data");
    pop(); idle(1);
    read_chk(STAT_AD, 32'h0, "a5_stat_after_pop");
    chk("a5_intr_after_pop", {31'b0, intr}, 32'h0);

    // overflow
    for (int b = 1; b <= 5; b++) send(8'(b), 1, -1, -1);
    idle(4);
    read_chk(STAT_AD, 32'hB, "ovr_stat");
    for (int b = 1; b <= 4; b++) begin
      read_chk(DATA_AD, 32'(b), "ovr_data");
      pop();
    end
    read_chk(STAT_AD, 32'h2, "ovr_stat_drained");
    stat_wr(32'h2);
    read_chk(STAT_AD, 32'h0, "ovr_cleared");

    // framing error then good frame
    send(8'h3C, 0, -1, -1); idle(4);
    read_chk(STAT_AD, 32'h4, "ferr_stat");
    send(8'h7E, 1, -1, -1); idle(4);
    read_chk(STAT_AD, 32'h5, "ferr_good_stat");
    read_chk(DATA_AD, 32'h7E, "ferr_good_data");
    pop(); stat_wr(32'h4);
    read_chk(STAT_AD, 32'h0, "ferr_cleared");

    // false start
    rx = 1'b0; repeat (4) tick(); idle(30);
    read_chk(STAT_AD, 32'h0, "false_start");

    // full FIFO, pop coincides with 5th push
    send(8'h11, 1, -1, -1); send(8'h22, 1, -1, -1);
    send(8'h33, 1, -1, -1); send(8'h44, 1, -1, -1);
    send(8'h55, 1, 9 * CPB + HALF + 2, -1); idle(4);
    read_chk(STAT_AD, 32'h9, "pushpop_stat");
    for (int b = 2; b <= 5; b++) begin
      read_chk(DATA_AD, 32'(b * 8'h11), "pushpop_data");
      pop();
    end
    read_chk(STAT_AD, 32'h0, "pushpop_drained");

    // reset mid-frame (during data bit 3)
    send(8'h99, 1, -1, -1); idle(2);
    read_chk(STAT_AD, 32'h1, "prerst_stat");
    send(8'hF8, 1, -1, 4 * CPB + 4); idle(4);
    read_chk(STAT_AD, 32'h0, "rst_mid_stat");
    read_chk(DATA_AD, 32'h0, "rst_mid_data");
    chk("rst_mid_intr", {31'b0, intr}, 32'h0);
    send(8'h5A, 1, -1, -1); idle(4);
    read_chk(DATA_AD, 32'h5A, "post_rst_data");
    pop(); idle(2);

    // random frames with concurrent random bus traffic
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          if ($urandom_range(0, 9) == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 7)) tick();
            rx = 1'b1;
          end else begin
            send(8'($urandom), $urandom_range(0, 7) != 0, -1, -1);
          end
          idle($urandom_range(0, 12));
        end
        done = 1;
      end
      begin
        while (!done) begin
          case ($urandom_range(0, 3))
            0, 1:    addr = DATA_AD;
            2:       addr = STAT_AD;
            default: addr = OTHR_AD;
          endcase
          wr    = ($urandom_range(0, 7) == 0);
          wdata = $urandom;
          tick();
        end
      end
    join
    wr = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
